// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the uart_tx arbiter and its helpers.
// Sits next to the existing baud defaults of the uart block.
package uart_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    WAIT_LOW  = 2'b01,
    WAIT_HIGH = 2'b10
  } arb_state_t;

  localparam int MAX_BURST_DEF = 16;
  localparam int ACCEPT_TO_DEF = 4;

  localparam int CLK_HZ_DEF   = 50_000_000;
  localparam int BAUD_DEF     = 115_200;
  localparam int BAUD_DIV_DEF = CLK_HZ_DEF / BAUD_DEF;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit at or after ptr.
// Shared by the tx arbiter and a future rx-side dispatcher.
module uart_tx_arbiter_rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [IW-1:0]   sel,
  output logic            any
);

  always_comb begin : pick
    int idx;
    idx = 0;
    sel = '0;
    any = |req;
    // Walk from the far end so the entry nearest ptr wins.
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = int'(ptr) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (req[idx]) sel = IW'(idx);
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter with burst lock in front of one uart_tx.
// Owners keep the serializer for up to MAX_BURST consecutive bytes.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int IW        = 2,
  parameter int MAX_BURST = MAX_BURST_DEF,
  parameter int ACCEPT_TO = ACCEPT_TO_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [NREQ-1:0]   i_req,
  input  logic [8*NREQ-1:0] i_data,
  output logic [NREQ-1:0]   o_ack,
  output logic              o_tx_start,
  output logic [7:0]        o_tx_data,
  input  logic              i_tx_ready,
  output logic              o_busy,
  output logic [IW-1:0]     o_owner
);

  localparam int TW = $clog2(ACCEPT_TO);

  arb_state_t      state, state_nx;
  logic [IW-1:0]   ptr, ptr_nx;
  logic [IW-1:0]   pick, idx, owner_nx;
  logic            any, issue;
  logic [7:0]      burst, burst_nx;
  logic [TW-1:0]   to_cnt, to_nx;
  logic [7:0]      data_nx;
  logic [NREQ-1:0] ack_nx;
  logic            start_nx;
  logic [7:0]      bytes [NREQ];

  for (genvar k = 0; k < NREQ; k++) begin : g_unpack
    assign bytes[k] = i_data[8*k +: 8];
  end

  uart_tx_arbiter_rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req (i_req),
    .ptr (ptr),
    .sel (pick),
    .any (any)
  );

  assign o_busy = (state != IDLE);

  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    burst_nx = burst;
    to_nx    = to_cnt;
    owner_nx = o_owner;
    data_nx  = o_tx_data;
    ack_nx   = '0;
    start_nx = 1'b0;
    issue    = 1'b0;
    idx      = pick;
    unique case (state)
      IDLE: begin
        if (any && i_tx_ready) begin
          issue    = 1'b1;
          idx      = pick;
          burst_nx = 8'd1;
        end
      end
      WAIT_LOW: begin
        to_nx = to_cnt + 1'b1;
        // A uart_tx that never drops ready still counts as accepted.
        if (!i_tx_ready || to_cnt == TW'(ACCEPT_TO - 1))
          state_nx = WAIT_HIGH;
      end
      WAIT_HIGH: begin
        if (i_tx_ready) begin
          if (i_req[o_owner] && burst < 8'(MAX_BURST)) begin
            issue    = 1'b1;
            idx      = o_owner;
            burst_nx = burst + 8'd1;
          end else begin
            ptr_nx   = (o_owner == IW'(NREQ - 1)) ? '0 : o_owner + 1'b1;
            burst_nx = '0;
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
    if (issue) begin
      state_nx = WAIT_LOW;
      to_nx    = '0;
      start_nx = 1'b1;
      owner_nx = idx;
      data_nx  = bytes[idx];
      ack_nx   = NREQ'(1) << idx;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      ptr        <= '0;
      burst      <= '0;
      to_cnt     <= '0;
      o_owner    <= '0;
      o_tx_data  <= '0;
      o_ack      <= '0;
      o_tx_start <= 1'b0;
    end else begin
      state      <= state_nx;
      ptr        <= ptr_nx;
      burst      <= burst_nx;
      to_cnt     <= to_nx;
      o_owner    <= owner_nx;
      o_tx_data  <= data_nx;
      o_ack      <= ack_nx;
      o_tx_start <= start_nx;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with requester and uart_tx models.
// Expected grants are queued per scenario and popped on each start.
module tb_uart_tx_arbiter;

  localparam int NREQ = 4;
  localparam int IW   = 2;
  localparam int ATO  = 4;

  typedef struct packed {
    logic [IW-1:0] own;
    logic [7:0]    d;
  } exp_t;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] data;
  logic [NREQ-1:0]   o_ack;
  logic              o_tx_start;
  logic [7:0]        o_tx_data;
  logic              tx_ready = 1'b1;
  logic              o_busy;
  logic [IW-1:0]     o_owner;

  int checks = 0;
  int fails  = 0;

  exp_t sb[$];
  logic [7:0] rbuf [NREQ][32];
  int rhead [NREQ];
  int rcnt  [NREQ];

  bit uart_dead = 1'b0;
  bit hold_low  = 1'b0;
  int busy_cnt  = 0;
  int cyc       = 0;
  int starts    = 0;
  int last_start = -100;
  int last_gap  = 0;

  uart_tx_arbiter #(
    .NREQ      (NREQ),
    .IW        (IW),
    .MAX_BURST (16),
    .ACCEPT_TO (ATO)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .i_req      (req),
    .i_data     (data),
    .o_ack      (o_ack),
    .o_tx_start (o_tx_start),
    .o_tx_data  (o_tx_data),
    .i_tx_ready (tx_ready),
    .o_busy     (o_busy),
    .o_owner    (o_owner)
  );

  always #5 clk = ~clk;

  always_comb begin
    req  = '0;
    data = '0;
    for (int k = 0; k < NREQ; k++) begin
      req[k]         = (rcnt[k] > 0);
      data[8*k +: 8] = rbuf[k][rhead[k]];
    end
  end

  always @(negedge clk) begin
    exp_t e;
    logic [NREQ-1:0] ack_w;
    cyc++;
    if (rstn && o_tx_start) begin
      starts++;
      last_gap   = cyc - last_start;
      last_start = cyc;
      checks++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL grant_unexpected: owner=%0d data=%h, none queued",
                 o_owner, o_tx_data);
      end else begin
        e = sb.pop_front();
        ack_w = NREQ'(1) << e.own;
        if ({o_owner, o_tx_data, o_ack} !== {e.own, e.d, ack_w}) begin
          fails++;
          $display("FAIL grant: owner=%0d data=%h ack=%b, want %0d %h %b",
                   o_owner, o_tx_data, o_ack, e.own, e.d, ack_w);
        end
      end
      if (starts > 1) begin
        checks++;
        if (last_gap < 3) begin
          fails++;
          $display("FAIL start_gap: got %0d, want >=3", last_gap);
        end
      end
    end else if (rstn && o_ack != '0) begin
      checks++;
      fails++;
      $display("FAIL ack_no_start: ack=%b, want 0", o_ack);
    end
    if (rstn) begin
      for (int k = 0; k < NREQ; k++) begin
        if (o_ack[k] && rcnt[k] > 0) begin
          rhead[k] = (rhead[k] + 1) % 32;
          rcnt[k]--;
        end
      end
    end
    if (rstn && o_tx_start && !uart_dead) busy_cnt = 6;
    else if (busy_cnt > 0) busy_cnt--;
    tx_ready = (busy_cnt == 0) && !hold_low;
  end

  task automatic load(input int k, input logic [7:0] b);
    rbuf[k][(rhead[k] + rcnt[k]) % 32] = b;
    rcnt[k]++;
  endtask

  task automatic expect_grant(input int k, input logic [7:0] b);
    exp_t e;
    e.own = IW'(k);
    e.d   = b;
    sb.push_back(e);
  endtask

  task automatic drain(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !o_busy &&
          rcnt[0] + rcnt[1] + rcnt[2] + rcnt[3] == 0) begin
        ok = 1'b1;
        break;
      end
    end
    @(negedge clk);
  endtask

  task automatic pulse_reset;
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_reset;
    #12;
    checks++;
    if ({o_ack, o_tx_start, o_tx_data, o_busy, o_owner} !== '0) begin
      fails++;
      $display("FAIL reset_vals: ack=%b st=%b d=%h busy=%b own=%0d, want 0",
               o_ack, o_tx_start, o_tx_data, o_busy, o_owner);
    end
    @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (o_busy !== 1'b0 || o_tx_start !== 1'b0) begin
      fails++;
      $display("FAIL idle_after_reset: busy=%b start=%b, want 0 0",
               o_busy, o_tx_start);
    end
  endtask

  task automatic test_single;
    bit ok;
    @(negedge clk);
    load(0, 8'h55);
    expect_grant(0, 8'h55);
    @(posedge clk);
    #1;
    checks++;
    if (o_tx_start !== 1'b1 || o_ack !== 4'b0001) begin
      fails++;
      $display("FAIL single_latency: start=%b ack=%b, want 1 0001",
               o_tx_start, o_ack);
    end
    checks++;
    if (o_busy !== 1'b1) begin
      fails++;
      $display("FAIL single_busy: busy=%b, want 1", o_busy);
    end
    drain(100, ok);
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL single_drain: timeout, pending=%0d", sb.size());
    end
    @(negedge clk);
    load(0, 8'hA0);
    load(1, 8'hA1);
    expect_grant(1, 8'hA1);
    expect_grant(0, 8'hA0);
    drain(100, ok);
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL ptr_after_single: timeout, pending=%0d", sb.size());
    end
  endtask

  task automatic test_contention;
    bit ok;
    pulse_reset();
    for (int r = 0; r < 2; r++) begin
      @(negedge clk);
      for (int k = 0; k < NREQ; k++) begin
        load(k, 8'(8'h10 + 16 * r + k));
      end
      for (int k = 0; k < NREQ; k++) begin
        expect_grant(k, 8'(8'h10 + 16 * r + k));
      end
      drain(200, ok);
      checks++;
      if (!ok) begin
        fails++;
        $display("FAIL contention_round%0d: timeout, pending=%0d",
                 r, sb.size());
      end
    end
  endtask

  task automatic test_burst_lock;
    bit ok;
    @(negedge clk);
    for (int i = 0; i < 20; i++) load(0, 8'(8'h80 + i));
    load(2, 8'hE2);
    for (int i = 0; i < 16; i++) expect_grant(0, 8'(8'h80 + i));
    expect_grant(2, 8'hE2);
    for (int i = 16; i < 20; i++) expect_grant(0, 8'(8'h80 + i));
    drain(1000, ok);
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL burst_lock: timeout, pending=%0d", sb.size());
    end
  endtask

  task automatic test_accept_timeout;
    bit ok;
    @(negedge clk);
    uart_dead = 1'b1;
    load(1, 8'hB1);
    load(1, 8'hB2);
    expect_grant(1, 8'hB1);
    expect_grant(1, 8'hB2);
    drain(100, ok);
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL timeout_drain: timeout, pending=%0d", sb.size());
    end
    checks++;
    if (last_gap != ATO + 1) begin
      fails++;
      $display("FAIL timeout_gap: got %0d, want %0d", last_gap, ATO + 1);
    end
    uart_dead = 1'b0;
  endtask

  task automatic test_ready_low;
    bit ok;
    int s0;
    @(negedge clk);
    hold_low = 1'b1;
    tx_ready = 1'b0;
    load(1, 8'h5A);
    expect_grant(1, 8'h5A);
    s0 = starts;
    repeat (50) @(negedge clk);
    checks++;
    if (starts != s0 || o_busy !== 1'b0 || o_ack !== '0) begin
      fails++;
      $display("FAIL ready_low_hold: starts=%0d busy=%b, want %0d 0",
               starts, o_busy, s0);
    end
    hold_low = 1'b0;
    tx_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (o_tx_start !== 1'b1 || o_owner !== 2'd1) begin
      fails++;
      $display("FAIL ready_rise_grant: start=%b owner=%0d, want 1 1",
               o_tx_start, o_owner);
    end
    drain(100, ok);
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL ready_low_drain: timeout, pending=%0d", sb.size());
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    @(negedge clk);
    load(0, 8'hC0);
    load(0, 8'hC1);
    load(0, 8'hC2);
    expect_grant(0, 8'hC0);
    @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    checks++;
    if ({o_ack, o_tx_start, o_tx_data, o_busy, o_owner} !== '0) begin
      fails++;
      $display("FAIL async_reset: ack=%b st=%b d=%h busy=%b own=%0d, want 0",
               o_ack, o_tx_start, o_tx_data, o_busy, o_owner);
    end
    sb.delete();
    rcnt[0] = 0;
    @(negedge clk);
    load(3, 8'h3C);
    expect_grant(3, 8'h3C);
    @(negedge clk);
    rstn = 1'b1;
    drain(100, ok);
    checks++;
    if (!ok || o_owner !== 2'd3) begin
      fails++;
      $display("FAIL reset_regrant: ok=%0d owner=%0d, want 1 3", ok, o_owner);
    end
  endtask

  initial begin
    for (int k = 0; k < NREQ; k++) begin
      rhead[k] = 0;
      rcnt[k]  = 0;
    end
    test_reset();
    test_single();
    test_contention();
    test_burst_lock();
    test_accept_timeout();
    test_ready_low();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one uart_tx serializer between NREQ byte producers (e.g. command echo, status reporter, debug dump).
- Round-robin arbitration with bounded burst lock, so a requester can send a multi-byte message without interleaving.
- Sits between the requesters and the uart_tx start/data/ready interface.
- Same clk domain as uart_tx.

Parameters:
- NREQ, 4, number of requesters (2..8)
- IW, 2, owner index width; must satisfy 2**IW >= NREQ
- MAX_BURST, 16, max consecutive bytes granted to one owner before forced rotation (1..255)
- ACCEPT_TO, 4, clocks to wait for i_tx_ready to fall after a start before treating the byte as accepted (>=2)

Ports:
- clk  in  1  system clock
- rstn  in  1  reset
- i_req  in  NREQ  per-requester "byte valid", level; held until o_ack
- i_data  in  8*NREQ  requester k byte on i_data[8k+7:8k]
- o_ack  out  NREQ  one-cycle pulse; byte of requester k taken
- o_tx_start  out  1  one-cycle pulse to uart_tx
- o_tx_data  out  8  byte to uart_tx, registered, stable from start until next start
- i_tx_ready  in  1  uart_tx idle (high) / shifting (low)
- o_busy  out  1  high whenever state != IDLE
- o_owner  out  IW  index of current/last granted requester

Behaviour:
- Interface: reset rstn, asynchronous, active-low; clock clk.
- Reset values: o_ack=0, o_tx_start=0, o_tx_data=0, o_busy=0, o_owner=0; rr pointer=0, burst_cnt=0, timeout cnt=0, state=IDLE.
- States: IDLE, WAIT_LOW, WAIT_HIGH.
- IDLE: if |i_req && i_tx_ready:
  - sel = first k with i_req[k]=1, searching ptr, ptr+1, ... modulo NREQ.
  - Next edge: o_tx_data<=i_data[sel], o_tx_start<=1, o_ack[sel]<=1, o_owner<=sel, burst_cnt<=1, to_cnt<=0, go to WAIT_LOW.
  - Latency: req sampled high at edge N gives start and ack high during cycle N+1.
  - Otherwise stay in IDLE.
- WAIT_LOW: to_cnt increments each cycle. Go to WAIT_HIGH when i_tx_ready==0 or to_cnt==ACCEPT_TO-1.
- WAIT_HIGH: wait for i_tx_ready==1, then:
  - If i_req[o_owner] && burst_cnt<MAX_BURST: issue again to the same owner (start, ack, latch data, burst_cnt+1, to_cnt<=0), go to WAIT_LOW.
  - Else: ptr<=(o_owner+1) mod NREQ, burst_cnt<=0, go to IDLE. Other requesters are arbitrated from IDLE on the following cycle.
- o_tx_start and o_ack are single-cycle pulses, never asserted in consecutive cycles. The minimum spacing between two starts is 3 cycles.
- Requester contract: after o_ack, deassert i_req or present the next byte within 1 cycle. i_req/i_data changes while not acked are legal; the arbiter samples only on issue.
- Pointer wrap: (NREQ-1)+1 -> 0. Pointer is updated only on owner release, never on a burst continuation.
- MAX_BURST=1 gives pure per-byte round-robin.
- i_tx_ready low in IDLE: no grant, no ack. Requests pend indefinitely; there is no starvation beyond NREQ*MAX_BURST bytes.
- Owner drops i_req in WAIT_HIGH: release on ready as above.
- Reset mid-operation: all state returns to reset values immediately. A byte already started in uart_tx is not tracked.
- Requests indexed >= NREQ do not exist. Unused owner codes are unreachable.

Decomposition:
- Shared package/header: state encodings (IDLE=2'b00, WAIT_LOW=2'b01, WAIT_HIGH=2'b10) and default MAX_BURST / ACCEPT_TO values, alongside the existing baud defines.
- One natural sub-module: rr_pick (combinational, parameter NREQ): inputs req vector and ptr; outputs sel index and any-valid. It is reusable by a future rx-side dispatcher.

Test Plan:
- Single request: i_req=4'b0001, data 0x55, ready high → start+ack[0] one cycle later, o_tx_data=0x55, o_busy high until ready returns; ptr becomes 1.
- Contention: i_req=4'b1111 each held for one byte, MAX_BURST=1, ptr=0 → grant order 0,1,2,3,0; each o_ack exactly once per byte.
- Burst lock: req0 sends 20 bytes back-to-back, req2 also pending, MAX_BURST=16 → 16 bytes of req0, then 1 of req2, then remaining 4 of req0.
- Accept timeout: i_tx_ready never falls after start → WAIT_HIGH entered exactly ACCEPT_TO cycles after start; the next start is issued normally.
- Ready low: i_tx_ready=0 with req1 pending for 50 cycles → no start, no ack; grant occurs 1 cycle after ready rises.
- Reset mid-burst: rstn pulsed low in WAIT_LOW → outputs go to 0 asynchronously; after release with req3 pending, arbitration restarts from ptr=0 and grants 3.
